// File: rtl/hazard_ctrl.sv
// hazard_ctrl: decode-stage hazard detection and forwarding-select generation
// for the five-stage MIPS pipeline. Tracks E/M/W destination records and
// derives stall (PC/D freeze, E bubble) plus D-stage forwarding selects.
// Optional MDU support is compiled in with `define HAZARD_MDU_EN.
module hazard_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR_D,
  output logic        PC_en,
  output logic        D_en,
  output logic        E_clr,
  output logic [1:0]  FCMP1D,
  output logic [1:0]  FCMP2D,
  output logic [1:0]  FPCD,
  output logic        mdu_busy
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic [1:0] SEL_RD = 2'b00;
  localparam logic [1:0] SEL_W  = 2'b01;
  localparam logic [1:0] SEL_M  = 2'b10;

  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd;

  assign op    = IR_D[31:26];
  assign rs    = IR_D[25:21];
  assign rt    = IR_D[20:16];
  assign rd    = IR_D[15:11];
  assign funct = IR_D[5:0];

  logic       rs_used, rt_used;
  logic [1:0] rs_tuse, rt_tuse;
  logic [4:0] dec_a3;
  logic [1:0] dec_tnew;
  logic       stall;

  // Stage records; W only needs A3 because its Tnew is always 0.
  logic [4:0] e_a3_q, e_a3_d, m_a3_q, m_a3_d, w_a3_q, w_a3_d;
  logic [1:0] e_tnew_q, e_tnew_d, m_tnew_q, m_tnew_d;

`ifdef HAZARD_MDU_EN
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;
  localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  logic             is_mdu, is_mul, is_div;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Decode the D-stage instruction into source usage, Tuse, A3 and Tnew.
  always_comb begin
    rs_used  = 1'b0;
    rt_used  = 1'b0;
    rs_tuse  = 2'd0;
    rt_tuse  = 2'd0;
    dec_a3   = 5'd0;
    dec_tnew = 2'd0;
`ifdef HAZARD_MDU_EN
    is_mdu = 1'b0;
    is_mul = 1'b0;
    is_div = 1'b0;
`endif
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU, FN_SUBU: begin
            rs_used  = 1'b1;
            rt_used  = 1'b1;
            rs_tuse  = 2'd1;
            rt_tuse  = 2'd1;
            dec_a3   = rd;
            dec_tnew = 2'd1;
          end
          FN_JR: rs_used = 1'b1;
`ifdef HAZARD_MDU_EN
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
            rs_used = 1'b1;
            rt_used = 1'b1;
            rs_tuse = 2'd1;
            rt_tuse = 2'd1;
            is_mdu  = 1'b1;
            is_mul  = (funct == FN_MULT) || (funct == FN_MULTU);
            is_div  = (funct == FN_DIV) || (funct == FN_DIVU);
          end
          FN_MFHI, FN_MFLO: begin
            dec_a3   = rd;
            dec_tnew = 2'd1;
            is_mdu   = 1'b1;
          end
          FN_MTHI, FN_MTLO: begin
            rs_used = 1'b1;
            rs_tuse = 2'd1;
            is_mdu  = 1'b1;
          end
`endif
          default: ;
        endcase
      end
      OP_ORI, OP_LUI: begin
        rs_used  = 1'b1;
        rs_tuse  = 2'd1;
        dec_a3   = rt;
        dec_tnew = 2'd1;
      end
      OP_LW: begin
        rs_used  = 1'b1;
        rs_tuse  = 2'd1;
        dec_a3   = rt;
        dec_tnew = 2'd2;
      end
      OP_SW: begin
        rs_used = 1'b1;
        rt_used = 1'b1;
        rs_tuse = 2'd1;
        rt_tuse = 2'd2;
      end
      OP_BEQ: begin
        rs_used = 1'b1;
        rt_used = 1'b1;
      end
      OP_JAL: begin
        dec_a3   = 5'd31;
        dec_tnew = 2'd1;
      end
      default: ;
    endcase
  end

  // Stall when a used source depends on an E/M producer not ready in time.
  always_comb begin
    stall = 1'b0;
    if (rs_used && rs != 5'd0) begin
      if (e_a3_q == rs && e_tnew_q > rs_tuse) stall = 1'b1;
      if (m_a3_q == rs && m_tnew_q > rs_tuse) stall = 1'b1;
    end
    if (rt_used && rt != 5'd0) begin
      if (e_a3_q == rt && e_tnew_q > rt_tuse) stall = 1'b1;
      if (m_a3_q == rt && m_tnew_q > rt_tuse) stall = 1'b1;
    end
`ifdef HAZARD_MDU_EN
    if (is_mdu && cnt_q != '0) stall = 1'b1;
`endif
  end

  // Forwarding selects: ready M result beats W result; $0 never forwards.
  always_comb begin
    FCMP1D = SEL_RD;
    FCMP2D = SEL_RD;
    if (rs_used && rs != 5'd0) begin
      if (m_a3_q == rs && m_tnew_q == 2'd0) FCMP1D = SEL_M;
      else if (w_a3_q == rs)                FCMP1D = SEL_W;
    end
    if (rt_used && rt != 5'd0) begin
      if (m_a3_q == rt && m_tnew_q == 2'd0) FCMP2D = SEL_M;
      else if (w_a3_q == rt)                FCMP2D = SEL_W;
    end
  end

  assign FPCD  = FCMP1D;
  assign PC_en = ~stall;
  assign D_en  = ~stall;
  assign E_clr = stall;

  // Advance the stage records, inserting a bubble into E on stall.
  always_comb begin
    e_a3_d   = stall ? 5'd0 : dec_a3;
    e_tnew_d = stall ? 2'd0 : dec_tnew;
    m_a3_d   = e_a3_q;
    m_tnew_d = (e_tnew_q == 2'd0) ? 2'd0 : e_tnew_q - 2'd1;
    w_a3_d   = m_a3_q;
  end

  // Stage record registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_a3_q   <= 5'd0;
      e_tnew_q <= 2'd0;
      m_a3_q   <= 5'd0;
      m_tnew_q <= 2'd0;
      w_a3_q   <= 5'd0;
    end else begin
      e_a3_q   <= e_a3_d;
      e_tnew_q <= e_tnew_d;
      m_a3_q   <= m_a3_d;
      m_tnew_q <= m_tnew_d;
      w_a3_q   <= w_a3_d;
    end
  end

`ifdef HAZARD_MDU_EN
  // MDU busy counter: load on mult/div issue, otherwise count down to 0.
  always_comb begin
    cnt_d = cnt_q;
    if (!stall && is_mul)      cnt_d = CNT_W'(MULT_CYC);
    else if (!stall && is_div) cnt_d = CNT_W'(DIV_CYC);
    else if (cnt_q != '0)      cnt_d = cnt_q - CNT_W'(1);
  end

  // MDU busy counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign mdu_busy = (cnt_q != '0);

  logic unused_bits;
  assign unused_bits = ^IR_D[10:6];
`else
  assign mdu_busy = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{IR_D[10:6], 32'(MULT_CYC), 32'(DIV_CYC)};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl: walks instruction pairs through D and
// checks stall/forwarding outputs against hand-derived expectations.
// Covers MDU behaviour when built with HAZARD_MDU_EN.
module tb_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] IR_D;
  logic        PC_en, D_en, E_clr, mdu_busy;
  logic [1:0]  FCMP1D, FCMP2D, FPCD;

  int total_checks = 0;
  int bad_checks   = 0;

  hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .IR_D     (IR_D),
    .PC_en    (PC_en),
    .D_en     (D_en),
    .E_clr    (E_clr),
    .FCMP1D   (FCMP1D),
    .FCMP2D   (FCMP2D),
    .FPCD     (FPCD),
    .mdu_busy (mdu_busy)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] NOP = 32'h0000_0000;

  function automatic logic [31:0] r_type(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input int rs, input int rt);
    return {op, 5'(rs), 5'(rt), 16'h0000};
  endfunction

  // Expected output bundle; FPCD always mirrors the rs select.
  function automatic logic [9:0] expv(input logic stall, input logic [1:0] f1,
                                      input logic [1:0] f2, input logic busy);
    return {~stall, ~stall, stall, f1, f2, f1, busy};
  endfunction

  logic [9:0] outs;
  assign outs = {PC_en, D_en, E_clr, FCMP1D, FCMP2D, FPCD, mdu_busy};

  task automatic checkOutput(input string tag, input logic [9:0] observed, input logic [9:0] expected);
    total_checks++;
    if (observed !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %b expected %b (PC_en,D_en,E_clr,F1,F2,FPC,busy)",
               tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] instr);
    IR_D = instr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    applyStimulus(NOP);
    repeat (3) tick();
  endtask

  initial begin
    reset = 1'b0;
    IR_D  = NOP;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_state", outs, expv(0, 2'b00, 2'b00, 0));
    reset = 1'b1;
    tick();
    checkOutput("after_reset", outs, expv(0, 2'b00, 2'b00, 0));

    // lw $1 then beq $1,$2: two stalls, then forward from W.
    applyStimulus(i_type(6'h23, 2, 1));
    checkOutput("lw_issue", outs, expv(0, 2'b00, 2'b00, 0));
    tick();
    applyStimulus(i_type(6'h04, 1, 2));
    checkOutput("lw_beq_stall1", outs, expv(1, 2'b00, 2'b00, 0));
    tick();
    checkOutput("lw_beq_stall2", outs, expv(1, 2'b00, 2'b00, 0));
    tick();
    checkOutput("lw_beq_fwd_w", outs, expv(0, 2'b01, 2'b00, 0));
    tick();
    flush();

    // addu $3 then beq $3,$3: one stall, then both from M.
    applyStimulus(r_type(1, 2, 3, 6'h21));
    tick();
    applyStimulus(i_type(6'h04, 3, 3));
    checkOutput("addu_beq_stall", outs, expv(1, 2'b00, 2'b00, 0));
    tick();
    checkOutput("addu_beq_fwd_m", outs, expv(0, 2'b10, 2'b10, 0));
    tick();
    flush();

    // lw $4 then sw $5,0($4): base needed at E, one stall.
    applyStimulus(i_type(6'h23, 7, 4));
    tick();
    applyStimulus(i_type(6'h2b, 4, 5));
    checkOutput("lw_sw_base_stall", outs, expv(1, 2'b00, 2'b00, 0));
    tick();
    checkOutput("lw_sw_base_go", outs, expv(0, 2'b00, 2'b00, 0));
    tick();
    flush();

    // lw $4 then sw $4,0($6): store data needed at M, no stall.
    applyStimulus(i_type(6'h23, 7, 4));
    tick();
    applyStimulus(i_type(6'h2b, 6, 4));
    checkOutput("lw_sw_data_nostall", outs, expv(0, 2'b00, 2'b00, 0));
    tick();
    flush();

    // jal then jr $31: one stall, then jr target from M.
    applyStimulus({6'h03, 26'h0000100});
    tick();
    applyStimulus(r_type(31, 0, 0, 6'h08));
    checkOutput("jal_jr_stall", outs, expv(1, 2'b00, 2'b00, 0));
    tick();
    checkOutput("jal_jr_fwd_m", outs, expv(0, 2'b10, 2'b00, 0));
    tick();
    flush();

    // Writes to $0 never create hazards or forwarding.
    applyStimulus(r_type(1, 2, 0, 6'h21));
    tick();
    applyStimulus(i_type(6'h04, 0, 0));
    checkOutput("zero_reg_e", outs, expv(0, 2'b00, 2'b00, 0));
    tick();
    checkOutput("zero_reg_m", outs, expv(0, 2'b00, 2'b00, 0));
    tick();
    flush();

    // Two writers of $8: M result must win over W result.
    applyStimulus(r_type(1, 2, 8, 6'h21));
    tick();
    applyStimulus(r_type(3, 4, 8, 6'h21));
    checkOutput("dup_write_issue", outs, expv(0, 2'b00, 2'b00, 0));
    tick();
    applyStimulus(i_type(6'h04, 8, 8));
    checkOutput("dup_write_stall", outs, expv(1, 2'b10, 2'b10, 0));
    tick();
    checkOutput("dup_write_m_prio", outs, expv(0, 2'b10, 2'b10, 0));
    tick();
    flush();

`ifdef HAZARD_MDU_EN
    // mult then mflo: mflo held for MULT_CYC cycles.
    applyStimulus(r_type(1, 2, 0, 6'h18));
    checkOutput("mult_issue", outs, expv(0, 2'b00, 2'b00, 0));
    tick();
    applyStimulus(r_type(0, 0, 9, 6'h12));
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("mflo_busy_%0d", i), outs, expv(1, 2'b00, 2'b00, 1));
      tick();
    end
    checkOutput("mflo_issue", outs, expv(0, 2'b00, 2'b00, 0));
    tick();
    flush();

    // divu then mfhi: held for DIV_CYC cycles.
    applyStimulus(r_type(1, 2, 0, 6'h1b));
    tick();
    applyStimulus(r_type(0, 0, 9, 6'h10));
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("mfhi_busy_%0d", i), outs, expv(1, 2'b00, 2'b00, 1));
      tick();
    end
    checkOutput("mfhi_issue", outs, expv(0, 2'b00, 2'b00, 0));
    tick();
    flush();

    // Reset inside the busy window clears counter and stall at once.
    applyStimulus(r_type(1, 2, 0, 6'h18));
    tick();
    applyStimulus(r_type(0, 0, 9, 6'h12));
    tick();
    checkOutput("mdu_pre_reset", outs, expv(1, 2'b00, 2'b00, 1));
    reset = 1'b0;
    #1;
    checkOutput("mdu_async_reset", outs, expv(0, 2'b00, 2'b00, 0));
    tick();
    reset = 1'b1;
    flush();
`else
    // Without MDU support, mult/mflo decode as nops.
    applyStimulus(r_type(1, 2, 0, 6'h18));
    checkOutput("mult_as_nop", outs, expv(0, 2'b00, 2'b00, 0));
    tick();
    applyStimulus(r_type(0, 0, 9, 6'h12));
    checkOutput("mflo_as_nop", outs, expv(0, 2'b00, 2'b00, 0));
    tick();
    flush();
`endif

    // Async reset during a load-use stall clears it within the cycle.
    applyStimulus(i_type(6'h23, 2, 1));
    tick();
    applyStimulus(i_type(6'h04, 1, 2));
    checkOutput("pre_reset_stall", outs, expv(1, 2'b00, 2'b00, 0));
    reset = 1'b0;
    #1;
    checkOutput("async_reset_clear", outs, expv(0, 2'b00, 2'b00, 0));
    tick();
    reset = 1'b1;
    tick();
    checkOutput("post_reset_idle", outs, expv(0, 2'b00, 2'b00, 0));

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Hazard and forwarding scheduler for the decode stage of the five-stage MIPS pipeline. It decodes the instruction in D and keeps a shadow record of the E, M and W stage destinations and their result readiness. From these it generates the freeze/bubble controls for PC, the D register and the E register. It also produces the D-stage forwarding selects for the compare operands and the jr target.

## Interface
Parameters:
- MULT_CYC, 5, busy cycles loaded for mult/multu.
- DIV_CYC, 10, busy cycles loaded for div/divu.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all stage records and the MDU counter.
- IR_D  in  32  instruction currently held in the D pipeline register.
- PC_en  out  1  PC write enable (= ~stall).
- D_en  out  1  D pipeline register enable (= ~stall).
- E_clr  out  1  synchronous clear of the E pipeline register, inserting a bubble (= stall).
- FCMP1D  out  2  select for the rs compare operand: 00 RD1, 01 WD (W result), 10 C_M (M result).
- FCMP2D  out  2  select for the rt compare operand, same encoding.
- FPCD  out  2  select for the jr target (rs), same encoding.
- mdu_busy  out  1  MDU counter nonzero.

## Operation
- Decode of IR_D gives per source (rs, rt) a Tuse value, plus the destination A3 and Tnew at E:
  - addu/subu: rs, rt Tuse 1; A3 = rd; Tnew 1.
  - ori/lui: rs Tuse 1; A3 = rt; Tnew 1.
  - lw: rs Tuse 1; A3 = rt; Tnew 2.
  - sw: rs Tuse 1, rt Tuse 2; no write.
  - beq: rs, rt Tuse 0.
  - jr: rs Tuse 0.
  - jal: A3 = 31; Tnew 1.
  - Anything else is a nop: no sources, A3 = 0.
- Tnew is the number of cycles until the value is at the M-stage output (C_M).
- Stage records hold {A3[4:0], Tnew[1:0]} for E, M and W, updated every clock:
  - E <= decoded D, or a bubble (A3 = 0) when stall = 1.
  - M <= E with Tnew decremented, saturating at 0.
  - W <= M with Tnew forced to 0.
- Stall rule: stall = 1 if any used source s with Tuse t meets both conditions:
  - it matches the E or M record (A3 == s, A3 != 0);
  - that record's Tnew > t.
- Forward rule, per source, for the D-stage selects:
  - M match with Tnew 0 gives 10.
  - Otherwise a W match gives 01.
  - Otherwise 00.
  - M has priority over W.
  - Register 0 never matches.
- FPCD is meaningful only for jr; it uses the rs select computation.
- All outputs are combinational from IR_D and the registered records. There is no extra output latency.

## Timing
- After reset deassertion: records empty, counter 0.
  - PC_en = 1, D_en = 1, E_clr = 0, all selects 00, mdu_busy = 0.
- reset asserted mid-operation clears records immediately (asynchronous), so outputs return to reset values within the same cycle.
- A stall holds PC and D, and inserts exactly one bubble into E per stalled cycle.
- The stall deasserts in the first cycle in which no producer with Tnew > Tuse remains in E or M.
- Simultaneous matches on rs and rt are evaluated independently; stall is the OR of both.

## Configuration
- HAZARD_MDU_EN defined: mult, multu, div, divu, mfhi, mflo, mthi and mtlo are decoded.
  - mult/multu sources are Tuse 1, A3 = 0. mfhi/mflo write rd with Tnew 1.
  - When a mult/div moves D->E (not stalled), the counter loads MULT_CYC or DIV_CYC.
  - The counter decrements by 1 per cycle while nonzero.
  - Any MDU instruction in D stalls while the counter != 0.
- HAZARD_MDU_EN undefined: these opcodes decode as nop, there is no counter, and mdu_busy is tied 0.

## Test plan
- lw $1 in E, beq $1,$2 in D:
  - stall = 1 for 2 cycles (E_clr = 1, PC_en = 0);
  - third cycle stall = 0, FCMP1D = 01.
- addu $3 in E, beq $3,$3 in D:
  - one stall cycle;
  - next cycle FCMP1D = FCMP2D = 10.
- lw $4 in E, sw $5,0($4) in D: one stall cycle. Repeated as sw $4,0($6): no stall.
- jal in E, jr $31 in D: one stall cycle, then FPCD = 10.
- addu $0 in E, beq $0,$0 in D: no stall, all selects 00.
- With HAZARD_MDU_EN, mult then mflo:
  - mdu_busy = 1 and stall = 1 for 5 cycles, then mflo issues.
  - Without the macro: no stall. Assert reset during the busy window: counter and stall clear immediately.
